// File: rtl/mriscv_isa_defs.sv
// RV32IM opcode/funct3 constants, the canonical NOP word and the encoder's
// internal types shared by the instruction encoder.
package mriscv_isa_defs;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_IRQ    = 7'b0011000;

    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_BLTX    = 3'b010;
    localparam logic [2:0] F3_BLTUX   = 3'b011;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_SYS_BAD = 3'b100;
    localparam logic [2:0] F3_IRQ_BAD = 3'b000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_U, FMT_J, FMT_I, FMT_B, FMT_S, FMT_SH, FMT_R
    } enc_fmt_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        illegal;
    } enc_word_t;

    // True when bits [31:msb] of v are all copies of one value (sign-extension form).
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] upper;
        upper = v >> msb;
        return (upper == 32'd0) || (upper == (32'hFFFF_FFFF >> msb));
    endfunction

endpackage

// File: rtl/instr_enc_core.sv
// Combinational RV32IM field encoder: internal code + fields -> {inst, illegal}.
// Immediate range checking is compiled in only with INSTR_ENC_IMM_CHECK_EN.
module instr_enc_core
    import mriscv_isa_defs::*;
(
    input  logic [11:0] code,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output enc_word_t   word
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        mext;
    logic        alt;
    enc_fmt_t    fmt;
    logic        legal;
    logic        imm_fit;
    logic [31:0] raw;

    assign opcode = code[6:0];
    assign funct3 = code[9:7];
    assign mext   = code[10];
    assign alt    = code[11];

    always_comb begin
        fmt   = FMT_I;
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; legal = 1'b1; end
            OPC_JAL:            begin fmt = FMT_J; legal = 1'b1; end
            OPC_JALR:           begin fmt = FMT_I; legal = (funct3 == F3_JALR); end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                legal = (funct3 != F3_BLTX) && (funct3 != F3_BLTUX);
            end
            OPC_LOAD: begin
                fmt   = FMT_I;
                legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                legal = funct3 inside {F3_SB, F3_SH, F3_SW};
            end
            OPC_OP_IMM: begin
                if (funct3[1:0] == 2'b01) begin
                    fmt   = FMT_SH;
                    legal = !((funct3 == F3_SLL) && mext);
                end else begin
                    fmt   = FMT_I;
                    legal = !mext;
                end
            end
            OPC_OP: begin
                fmt   = FMT_R;
                legal = (!mext || (!funct3[2] && !alt)) &&
                        (!alt || funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA);
            end
            OPC_SYSTEM: begin fmt = FMT_I; legal = (funct3 != F3_SYS_BAD); end
            OPC_IRQ:    begin fmt = FMT_I; legal = (funct3 != F3_IRQ_BAD); end
            default:    begin fmt = FMT_I; legal = 1'b0; end
        endcase
        // The funct7 discriminators only have an encoding inside OP (both) and OP-IMM (mext).
        if (alt && opcode != OPC_OP)
            legal = 1'b0;
        if (mext && opcode != OPC_OP && opcode != OPC_OP_IMM)
            legal = 1'b0;
    end

    always_comb begin
        case (fmt)
            FMT_U:   raw = {imm[31:12], rd, opcode};
            FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_I:   raw = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_SH:  raw = {1'b0, mext, 5'b00000, imm[4:0], rs1, funct3, rd, opcode};
            default: raw = {1'b0, alt, 4'b0000, mext, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef INSTR_ENC_IMM_CHECK_EN
    always_comb begin
        case (fmt)
            FMT_U:   imm_fit = (imm[11:0] == 12'd0);
            FMT_J:   imm_fit = fits_signed(imm, 20) && !imm[0];
            FMT_B:   imm_fit = fits_signed(imm, 12) && !imm[0];
            FMT_I,
            FMT_S:   imm_fit = fits_signed(imm, 11);
            FMT_SH:  imm_fit = (imm[11:5] == 7'd0);
            default: imm_fit = 1'b1;
        endcase
    end
`else
    assign imm_fit = 1'b1;
`endif

    assign word.illegal = !(legal && imm_fit);
    assign word.inst    = word.illegal ? NOP_WORD : raw;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: request handshake, 2-entry output FIFO and counters.
// Optional immediate range check selected by INSTR_ENC_IMM_CHECK_EN.
module instr_encoder
    import mriscv_isa_defs::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_code,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_illegal,
    output logic [CNT_W-1:0] n_emitted,
    output logic [ERR_W-1:0] n_illegal
);

    enc_word_t        enc_word;
    logic [31:0]      inst_reg    [2];
    logic             illegal_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [CNT_W-1:0] n_emitted_reg;
    logic [ERR_W-1:0] n_illegal_reg;
    logic             push;
    logic             pop;

    instr_enc_core u_core (
        .code (in_code),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .word (enc_word)
    );

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign in_ready  = (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    inst_reg[gi]    <= 32'd0;
                    illegal_reg[gi] <= 1'b0;
                end else if (push && wr_ptr_reg == 1'(gi)) begin
                    inst_reg[gi]    <= enc_word.inst;
                    illegal_reg[gi] <= enc_word.illegal;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            n_emitted_reg <= '0;
            n_illegal_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= !wr_ptr_reg;
            if (pop) begin
                rd_ptr_reg    <= !rd_ptr_reg;
                n_emitted_reg <= n_emitted_reg + CNT_W'(1);
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            if (push && enc_word.illegal && n_illegal_reg != '1)
                n_illegal_reg <= n_illegal_reg + ERR_W'(1);
        end
    end

    assign out_inst    = inst_reg[rd_ptr_reg];
    assign out_illegal = illegal_reg[rd_ptr_reg];
    assign n_emitted   = n_emitted_reg;
    assign n_illegal   = n_illegal_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, back-pressure,
// mid-operation reset and randomized traffic against a behavioural model.
module tb_instr_encoder;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_code;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_illegal;
    logic [CNT_W-1:0] n_emitted;
    logic [ERR_W-1:0] n_illegal;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] inst;
        logic        ill;
    } exp_t;

    exp_t expq[$];
    int   exp_emitted;
    int   exp_illegal;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_illegal (out_illegal),
        .n_emitted   (n_emitted),
        .n_illegal   (n_illegal)
    );

    // Behavioural reference: builds the word arithmetically from the ISA field rules.
    function automatic void ref_encode(input logic [11:0] code, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm,
                                       output logic [31:0] inst, output logic ill);
        int unsigned op  = 32'(code[6:0]);
        int unsigned f3  = 32'(code[9:7]);
        int unsigned m   = 32'(code[10]);
        int unsigned alt = 32'(code[11]);
        int unsigned d   = 32'(rd);
        int unsigned r1  = 32'(rs1);
        int unsigned r2  = 32'(rs2);
        int unsigned u   = imm;
        int          s   = $signed(imm);
        int unsigned itype;
        int unsigned w   = 0;
        bit          ok  = 0;
        bit          fit = 1;
        bit          irange;
        itype  = ((u & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
        irange = (s >= -2048) && (s <= 2047);
        case (op)
            32'h37, 32'h17: begin
                ok = 1; w = (u & 32'hFFFF_F000) | (d << 7) | op; fit = (u % 4096) == 0;
            end
            32'h6F: begin
                ok = 1;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | (d << 7) | op;
                fit = (s >= -(1 << 20)) && (s < (1 << 20)) && (u % 2 == 0);
            end
            32'h67: begin ok = (f3 == 0); w = itype; fit = irange; end
            32'h63: begin
                ok = !(f3 == 2 || f3 == 3);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15) |
                    (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | op;
                fit = (s >= -4096) && (s <= 4095) && (u % 2 == 0);
            end
            32'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); w = itype; fit = irange; end
            32'h23: begin
                ok = (f3 <= 2);
                w = (((u >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | ((u & 31) << 7) | op;
                fit = irange;
            end
            32'h13: begin
                if (f3 % 4 == 1) begin
                    ok = !(f3 == 1 && m == 1);
                    w = (m << 30) | ((u & 31) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
                    fit = ((u >> 5) & 127) == 0;
                end else begin
                    ok = (m == 0); w = itype; fit = irange;
                end
            end
            32'h33: begin
                ok = (m == 0 || (f3 < 4 && alt == 0)) && (alt == 0 || f3 == 0 || f3 == 5);
                w = (alt << 30) | (m << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
                fit = 1;
            end
            32'h73: begin ok = (f3 != 4); w = itype; fit = irange; end
            32'h18: begin ok = (f3 != 0); w = itype; fit = irange; end
            default: ok = 0;
        endcase
        if (alt != 0 && op != 32'h33) ok = 0;
        if (m != 0 && op != 32'h33 && op != 32'h13) ok = 0;
`ifdef INSTR_ENC_IMM_CHECK_EN
        ok = ok && fit;
`endif
        ill  = !ok;
        inst = ok ? w : 32'h0000_0013;
    endfunction

    task automatic gen_fields(output logic [11:0] c, output logic [4:0] d, output logic [4:0] s1,
                              output logic [4:0] s2, output logic [31:0] im);
        logic [6:0] op;
        logic [1:0] hi;
        int         tmp;
        case ($urandom_range(0, 11))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
            8: op = 7'h33;  9: op = 7'h73; 10: op = 7'h18;
            default: op = 7'($urandom);
        endcase
        hi = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        c  = {hi, 3'($urandom), op};
        d  = 5'($urandom);
        s1 = 5'($urandom);
        s2 = 5'($urandom);
        case ($urandom_range(0, 3))
            0: begin tmp = int'($urandom_range(0, 4095)) - 2048; im = 32'(tmp); end
            1: begin tmp = (int'($urandom_range(0, 4095)) - 2048) * 2; im = 32'(tmp); end
            2: im = $urandom & 32'hFFFF_F000;
            default: im = $urandom;
        endcase
    endtask

    task automatic apply_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rstn      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        expq.delete();
        exp_emitted = 0;
        exp_illegal = 0;
    endtask

    task automatic test_reset;
        in_code = 12'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        apply_reset();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_inst !== 32'd0) begin failed++; $display("FAIL reset_out_inst got %h want 00000000", out_inst); end
        tests++; if (out_illegal !== 1'b0) begin failed++; $display("FAIL reset_out_illegal got %b want 0", out_illegal); end
        tests++; if (n_emitted !== '0) begin failed++; $display("FAIL reset_n_emitted got %0d want 0", n_emitted); end
        tests++; if (n_illegal !== '0) begin failed++; $display("FAIL reset_n_illegal got %0d want 0", n_illegal); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("[TB] reset done");
    endtask

    task automatic send_directed(input string name, input logic [11:0] c, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                                 input logic [31:0] want_inst, input logic want_ill);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL %s_pre_valid got %b want 0", name, out_valid); end
        in_code = c; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (want_ill && exp_illegal < 255) exp_illegal++;
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL %s_latency out_valid got %b want 1", name, out_valid); end
        tests++; if (out_inst !== want_inst) begin failed++; $display("FAIL %s_inst got %h want %h", name, out_inst, want_inst); end
        tests++; if (out_illegal !== want_ill) begin failed++; $display("FAIL %s_illegal got %b want %b", name, out_illegal, want_ill); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_emitted++;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL %s_post_valid got %b want 0", name, out_valid); end
        tests++; if (n_emitted !== 16'(exp_emitted)) begin failed++; $display("FAIL %s_n_emitted got %0d want %0d", name, n_emitted, exp_emitted); end
        tests++; if (n_illegal !== 8'(exp_illegal)) begin failed++; $display("FAIL %s_n_illegal got %0d want %0d", name, n_illegal, exp_illegal); end
        $display("[TB] %s code=%h inst=%h illegal=%b", name, c, out_inst, out_illegal);
    endtask

    task automatic test_directed;
        apply_reset();
        send_directed("addi", 12'h013, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0);
        send_directed("add",  12'h033, 5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3, 1'b0);
        send_directed("sub",  12'h833, 5'd3, 5'd1, 5'd2, 32'd0,          32'h4020_81B3, 1'b0);
        send_directed("mul",  12'h433, 5'd3, 5'd1, 5'd2, 32'd0,          32'h0220_81B3, 1'b0);
        send_directed("beq",  12'h063, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0);
        send_directed("lui",  12'h037, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        send_directed("jal",  12'h06F, 5'd1, 5'd0, 5'd0, 32'd16,         32'h0100_00EF, 1'b0);
        send_directed("srai", 12'h693, 5'd1, 5'd2, 5'd0, 32'd3,          32'h4031_5093, 1'b0);
        send_directed("bad_branch", 12'h163, 5'd0, 5'd1, 5'd2, 32'd8,    32'h0000_0013, 1'b1);
        send_directed("sub_on_addi", 12'h813, 5'd1, 5'd0, 5'd0, 32'd5,   32'h0000_0013, 1'b1);
`ifdef INSTR_ENC_IMM_CHECK_EN
        send_directed("beq_odd", 12'h063, 5'd0, 5'd1, 5'd2, 32'd7,      32'h0000_0013, 1'b1);
`else
        send_directed("beq_odd", 12'h063, 5'd0, 5'd1, 5'd2, 32'd7,      32'h0020_8363, 1'b0);
`endif
    endtask

    task automatic test_back_to_back;
        logic [31:0] bp_inst [3];
        logic        bp_ill  [3];
        logic [11:0] c;
        logic [4:0]  d, s1, s2;
        logic [31:0] im;
        int          idx = 0;
        int          n_bad = 0;
        bit          accepted = 0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            gen_fields(c, d, s1, s2, im);
            ref_encode(c, d, s1, s2, im, bp_inst[k], bp_ill[k]);
            if (bp_ill[k]) n_bad++;
            in_code = c; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
            in_valid = 1'b1;
            tests++; if (in_ready !== (k < 2)) begin failed++; $display("FAIL b2b_in_ready_%0d got %b want %b", k, in_ready, k < 2); end
            if (k < 2) begin @(posedge clk); #1; end
        end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL b2b_full_hold got %b want 0", in_ready); end
        tests++; if (out_inst !== bp_inst[0]) begin failed++; $display("FAIL b2b_head got %h want %h", out_inst, bp_inst[0]); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            if (out_valid) begin
                tests++; if (out_inst !== bp_inst[idx] || out_illegal !== bp_ill[idx]) begin
                    failed++; $display("FAIL b2b_pop_%0d got %h/%b want %h/%b", idx, out_inst, out_illegal, bp_inst[idx], bp_ill[idx]);
                end
                $display("[TB] b2b pop %0d inst=%h illegal=%b", idx, out_inst, out_illegal);
                idx++;
            end
            if (in_valid && in_ready) accepted = 1;
            @(posedge clk); #1;
            if (accepted) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        tests++; if (idx != 3) begin failed++; $display("FAIL b2b_timeout popped %0d want 3", idx); end
        tests++; if (n_emitted !== 16'd3) begin failed++; $display("FAIL b2b_n_emitted got %0d want 3", n_emitted); end
        tests++; if (n_illegal !== 8'(n_bad)) begin failed++; $display("FAIL b2b_n_illegal got %0d want %0d", n_illegal, n_bad); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL b2b_drained got %b want 0", out_valid); end
    endtask

    task automatic test_random;
        logic [11:0] c;
        logic [4:0]  d, s1, s2;
        logic [31:0] im;
        exp_t        e;
        exp_t        h;
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            gen_fields(c, d, s1, s2, im);
            in_code = c; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            tests++; if (in_ready !== (expq.size() < 2)) begin failed++; $display("FAIL rnd_in_ready c%0d got %b want %b", cyc, in_ready, expq.size() < 2); end
            tests++; if (out_valid !== (expq.size() > 0)) begin failed++; $display("FAIL rnd_out_valid c%0d got %b want %b", cyc, out_valid, expq.size() > 0); end
            if (out_valid && out_ready && expq.size() > 0) begin
                h = expq.pop_front();
                tests++; if (out_inst !== h.inst || out_illegal !== h.ill) begin
                    failed++; $display("FAIL rnd_pop c%0d got %h/%b want %h/%b", cyc, out_inst, out_illegal, h.inst, h.ill);
                end
                $display("[TB] rnd pop inst=%h illegal=%b", out_inst, out_illegal);
                exp_emitted++;
            end
            if (in_valid && in_ready) begin
                ref_encode(c, d, s1, s2, im, e.inst, e.ill);
                expq.push_back(e);
                if (e.ill && exp_illegal < 255) exp_illegal++;
            end
            @(posedge clk); #1;
            tests++; if (n_emitted !== 16'(exp_emitted) || n_illegal !== 8'(exp_illegal)) begin
                failed++; $display("FAIL rnd_counters c%0d got %0d/%0d want %0d/%0d", cyc, n_emitted, n_illegal, exp_emitted, exp_illegal);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && expq.size() > 0; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                h = expq.pop_front();
                tests++; if (out_inst !== h.inst || out_illegal !== h.ill) begin
                    failed++; $display("FAIL rnd_drain got %h/%b want %h/%b", out_inst, out_illegal, h.inst, h.ill);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        tests++; if (expq.size() != 0 || out_valid !== 1'b0) begin
            failed++; $display("FAIL rnd_drain_timeout left %0d out_valid %b want 0/0", expq.size(), out_valid);
        end
    endtask

    task automatic test_reset_midop;
        in_code = 12'h163; in_rd = 5'd0; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 32'd8;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_code = 12'h013;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failed++; $display("FAIL midrst_full got ready %b valid %b want 0/1", in_ready, out_valid);
        end
        tests++; if (n_illegal === '0 || n_emitted === '0) begin
            failed++; $display("FAIL midrst_precount got %0d/%0d want nonzero", n_emitted, n_illegal);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        tests++; if (n_emitted !== '0 || n_illegal !== '0) begin
            failed++; $display("FAIL midrst_counters got %0d/%0d want 0/0", n_emitted, n_illegal);
        end
        tests++; if (out_inst !== 32'd0) begin failed++; $display("FAIL midrst_out_inst got %h want 00000000", out_inst); end
        @(posedge clk); #1;
        rstn = 1'b1;
        $display("[TB] mid-operation reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Converts decoded instruction fields (12-bit internal code, rd/rs1/rs2 indices, 32-bit immediate) back into a 32-bit RV32IM instruction word.
- The code format is the one the core decoder produces: code[6:0]=opcode, code[9:7]=funct3, code[10]/code[11]=funct7 discriminators.
- Used by the SQED duplicate-instruction generator and the program loader to build instruction streams.
- Valid/ready handshake on input. Registered 2-entry output buffer with valid/ready.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.
- ERR_W, 8, width of the saturating illegal-request counter.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_code  in  12  {code[11], code[10], funct3, opcode}
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate, decoder bit layout
- out_valid  out  1  word available
- out_ready  in  1  consumer pops when out_valid & out_ready
- out_inst  out  32  encoded instruction
- out_illegal  out  1  the word is a substituted NOP for an illegal request
- n_emitted  out  CNT_W  words popped, wraps
- n_illegal  out  ERR_W  illegal requests accepted, saturates at all-ones

Behaviour:
- Reset values: out_valid=0, out_inst=0, out_illegal=0, n_emitted=0, n_illegal=0, FIFO count=0, in_ready=1.
- Reset asserted mid-operation flushes the FIFO and clears both counters immediately.
- Storage: 2-entry FIFO of {inst, illegal}.
  - in_ready = (count<2).
  - Push and pop in the same cycle with count=2 is not accepted: in_ready is 0.
  - Push and pop in the same cycle with count=1 keeps count=1.
  - Head is presented on out_inst/out_illegal.
- Latency: request accepted at edge N is visible at out_valid after edge N, if the FIFO was empty. Order is preserved.
- Register fields: rd→[11:7], rs1→[19:15], rs2→[24:20], opcode→[6:0], funct3→[14:12] where the format has them. Unused fields are 0.
- Encoding per opcode:
  - 0110111/0010111 (lui/auipc): [31:12]=imm[31:12]; legal.
  - 1101111 (jal): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; legal.
  - 1100111 (jalr): I-type, [31:20]=imm[11:0]; legal only if funct3=000.
  - 1100011 (branch): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; illegal if funct3 is 010 or 011.
  - 0000011 (load): I-type; legal if funct3 is 000, 001, 010, 100 or 101.
  - 0100011 (store): [31:25]=imm[11:5], [11:7]=imm[4:0]; legal if funct3 is 000, 001 or 010.
  - 0010011 (OP-IMM), funct3 x01 (shift): [31:25]={0,code[10],00000}, [24:20]=imm[4:0]; slli requires code[10]=0.
  - 0010011 (OP-IMM), other funct3: I-type, and code[10] must be 0.
  - 0110011 (OP): funct7={0,code[11],0000,code[10]}.
    - code[10]=1 (M extension) requires funct3[2]=0 and code[11]=0.
    - code[11]=1 requires funct3 000 or 101.
  - 1110011 (SYSTEM): [31:20]=imm[11:0]; illegal if funct3=100.
  - 0011000 (IRQ): [31:20]=imm[11:0], rs2 ignored; illegal if funct3=000.
  - Any other opcode is illegal. code[11:10]≠00 outside OP and OP-IMM is illegal.
- Illegal request: still accepted. Pushes 32'h00000013 with illegal=1. n_illegal increments, saturating.
- n_emitted increments on every pop, wrapping modulo 2^CNT_W.

Optional Feature:
- Macro INSTR_ENC_IMM_CHECK_EN.
- Defined: an immediate is also illegal if it does not fit its format.
  - I/S-type: sign-extends from bit 11.
  - B-type: fits in 13 bits with imm[0]=0.
  - J-type: fits in 21 bits with imm[0]=0.
  - U-type: imm[11:0]=0.
  - Shift: imm[11:5]=0.
- Not defined: out-of-range bits are silently truncated and no range check logic exists.

Decomposition:
- Package/header mriscv_isa_defs: opcode constants, funct3 constants, NOP word 32'h00000013.
- One combinational sub-module instr_enc_core (code/fields → {inst, illegal}).
- FIFO, handshake and counters stay in the top.

Test Plan:
- addi x1,x0,5 (code 12'h013, rd=1, imm=5) → out_inst=0x00500093, out_illegal=0, out_valid one cycle after accept.
- add x3,x1,x2 (code 12'h033) → 0x002081B3; sub (code 12'h833) → 0x402081B3.
- beq x1,x2,+8 (code 12'h063, imm=8) → 0x00208463; lui x5 (code 12'h037, imm=0x12345000) → 0x123452B7.
- Illegal branch funct3=010 (code 12'h163) → 0x00000013, out_illegal=1, n_illegal=1.
- out_ready=0, three back-to-back requests → two accepted, in_ready=0 on the third. Release out_ready → words pop in order, n_emitted=3.
- rstn low while count=2 → out_valid=0 and counters=0 immediately. With INSTR_ENC_IMM_CHECK_EN, beq with imm=7 → NOP and illegal=1.
